// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared FSM state type and shift-mode encodings for the shift sequencer
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_LOGICAL = 1'b0;
   localparam logic MODE_ARITH   = 1'b1;

endpackage

// File: rtl/shift_seq.sv
// shift_seq: splits long right shifts into passes of at most WIDTH-1 bits through an external shifter
// Optional macro SHIFT_SEQ_SAT_EN: amounts >= WIDTH finish immediately with the saturated fill value.
module shift_seq
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [AMT_W-1:0]         in_shamt,
   input  logic                     in_mode,
   output logic [WIDTH-1:0]         sh_data,
   output logic [$clog2(WIDTH)-1:0] sh_shift,
   output logic                     sh_mode,
   input  logic [WIDTH-1:0]         sh_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data
);

   localparam int SW       = $clog2(WIDTH);
   localparam int MAX_STEP = WIDTH - 1;

   state_t           state, nxt;
   logic [WIDTH-1:0] acc;
   logic [AMT_W-1:0] rem;
   logic             mode_q;
   logic [SW-1:0]    step;
   logic             accept;
   logic             last;
   logic             sat;
   logic [WIDTH-1:0] load;

   // Largest pass the shifter can take this cycle, and whether it finishes the op
   always_comb begin
      step = (32'(rem) > 32'(MAX_STEP)) ? SW'(MAX_STEP) : SW'(rem);
      last = 32'(rem) == 32'(step);
   end

   // Handshakes and shifter drive; shift amount is forced to zero outside RUN
   always_comb begin
      in_ready  = rst_n && (state == IDLE);
      accept    = in_valid && in_ready;
      out_valid = state == DONE;
      out_data  = acc;
      sh_data   = acc;
      sh_mode   = mode_q;
      sh_shift  = (state == RUN) ? step : '0;
   end

   // Saturating shortcut decides what gets loaded on accept
   always_comb begin
`ifdef SHIFT_SEQ_SAT_EN
      sat = 32'(in_shamt) >= 32'(WIDTH);
`else
      sat = 1'b0;
`endif
      load = sat ? ((in_mode == MODE_ARITH) ? {WIDTH{in_data[WIDTH-1]}} : '0) : in_data;
   end

   // Next-state: zero or saturated amounts skip RUN entirely
   always_comb begin
      nxt = state;
      if (state == IDLE && in_valid)
         nxt = (sat || in_shamt == '0) ? DONE : RUN;
      else if (state == RUN && last)
         nxt = DONE;
      else if (state == DONE && out_ready)
         nxt = IDLE;
   end

   // State, accumulator and remaining-amount registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         rem    <= '0;
         mode_q <= MODE_LOGICAL;
      end else begin
         state <= nxt;
         if (accept) begin
            acc    <= load;
            rem    <= in_shamt;
            mode_q <= in_mode;
         end else if (state == RUN) begin
            acc <= sh_result;
            rem <= rem - AMT_W'(step);
         end
      end
   end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq with a behavioural right shifter on the sh_* side
module tb_shift_seq;
   import shift_seq_pkg::*;

   logic       clk = 0, rst_n = 0, in_valid = 0, in_mode = 0, out_ready = 1;
   logic [7:0] in_data = 0, in_shamt = 0;
   logic       in_ready, out_valid, sh_mode;
   logic [7:0] sh_data, sh_result, out_data;
   logic [2:0] sh_shift;
   int         cyc = 0, t_acc = 0, n_tests = 0, n_fail = 0;

   typedef struct {
      logic [7:0] data;
      int         lat;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-pass right shifter
   always_comb sh_result = 8'({{8{sh_mode & sh_data[7]}}, sh_data} >> sh_shift);

   shift_seq #(.WIDTH(8), .AMT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
      .sh_data(sh_data), .sh_shift(sh_shift), .sh_mode(sh_mode), .sh_result(sh_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   function automatic logic [7:0] exp_shift(input logic [7:0] d, input int s, input logic m);
      logic signed [7:0] sd, r;
      if (s >= 8) return m ? {8{d[7]}} : 8'h00;
      if (!m) return d >> s;
      sd = d;
      r  = sd >>> s;
      return r;
   endfunction

   function automatic int pcount(input int s);
`ifdef SHIFT_SEQ_SAT_EN
      if (s >= 8) return 0;
`endif
      return (s + 6) / 7;
   endfunction

   task automatic issue(input logic [7:0] d, input logic [7:0] s, input logic m, input bit push);
      in_valid = 1; in_data = d; in_shamt = s; in_mode = m; t_acc = cyc;
      if (push) q.push_back('{exp_shift(d, int'(s), m), 1 + pcount(int'(s))});
      @(negedge clk);
      in_valid = 0; in_data = 8'($urandom); in_shamt = 8'($urandom); in_mode = 1'($urandom);
   endtask

   task automatic wait_out(output int lat);
      bit done;
      lat = -1; done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (out_valid) begin lat = cyc - t_acc; done = 1; end
         else @(negedge clk);
      end
      if (!done) begin n_tests++; n_fail++; $display("FAIL wait_out: out_valid never rose"); end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h want 00", out_data); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low got %b want 0", in_ready); end
      rst_n = 1;
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_idle got %b want 1", in_ready); end
   endtask

   task automatic test_single_pass;
      int lat; exp_t e;
      for (int m = 0; m < 2; m++) begin
         issue(8'hB4, 8'd3, 1'(m), 1);
         n_tests++; if (sh_shift !== 3'd3) begin n_fail++; $display("FAIL single_sh_shift m=%0d got %0d want 3", m, sh_shift); end
         wait_out(lat); e = q.pop_front();
         n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL single_lat m=%0d got %0d want %0d", m, lat, e.lat); end
         n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL single_data m=%0d got %h want %h", m, out_data, e.data); end
         @(negedge clk);
      end
   endtask

   task automatic test_multipass;
      int lat; exp_t e;
      for (int m = 1; m >= 0; m--) begin
         issue(8'h80, 8'd10, 1'(m), 1);
`ifndef SHIFT_SEQ_SAT_EN
         n_tests++; if (sh_shift !== 3'd7) begin n_fail++; $display("FAIL multi_pass1 got %0d want 7", sh_shift); end
         @(negedge clk);
         n_tests++; if (sh_shift !== 3'd3) begin n_fail++; $display("FAIL multi_pass2 got %0d want 3", sh_shift); end
`endif
         wait_out(lat); e = q.pop_front();
         n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL multi_lat m=%0d got %0d want %0d", m, lat, e.lat); end
         n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL multi_data m=%0d got %h want %h", m, out_data, e.data); end
         @(negedge clk);
      end
   endtask

   task automatic test_zero;
      int lat; exp_t e;
      issue(8'h5A, 8'd0, 1'b0, 1);
      n_tests++; if (sh_shift !== 3'd0) begin n_fail++; $display("FAIL zero_sh_shift got %0d want 0", sh_shift); end
      wait_out(lat); e = q.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL zero_lat got %0d want %0d", lat, e.lat); end
      n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL zero_data got %h want %h", out_data, e.data); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int lat; exp_t e; logic [7:0] held;
      out_ready = 0;
      issue(8'hC3, 8'd5, 1'b1, 1);
      wait_out(lat); e = q.pop_front();
      n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL bp_data got %h want %h", out_data, e.data); end
      held = e.data;
      in_valid = 1; in_data = 8'h11; in_shamt = 8'd1; in_mode = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d got %b want 1", i, out_valid); end
         n_tests++; if (out_data !== held) begin n_fail++; $display("FAIL bp_stable cyc%0d got %h want %h", i, out_data, held); end
         n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
      end
      out_ready = 1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_ready got %b want 1", in_ready); end
      issue(8'h11, 8'd1, 1'b0, 1);
      wait_out(lat); e = q.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL bp_next_lat got %0d want %0d", lat, e.lat); end
      n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL bp_next_data got %h want %h", out_data, e.data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit seen = 0;
      issue(8'h80, 8'd200, 1'b1, 0);
      rst_n = 0;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready_low got %b want 0", in_ready); end
      rst_n = 1;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got %b want 1", in_ready); end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got %b want 0", seen); end
   endtask

   task automatic test_latency;
      int lat; exp_t e;
      issue(8'h80, 8'd200, 1'b1, 1);
      wait_out(lat); e = q.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL long_lat got %0d want %0d", lat, e.lat); end
      n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL long_data got %h want %h", out_data, e.data); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int lat; exp_t e;
      for (int i = 0; i < 8; i++) begin
         issue(8'($urandom), 8'($urandom_range(0, 20)), 1'($urandom), 1);
         wait_out(lat); e = q.pop_front();
         n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_lat op%0d got %0d want %0d", i, lat, e.lat); end
         n_tests++; if (out_data !== e.data) begin n_fail++; $display("FAIL b2b_data op%0d got %h want %h", i, out_data, e.data); end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset;
      test_single_pass;
      test_multipass;
      test_zero;
      test_backpressure;
      test_reset_mid;
      test_latency;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
